// File: rtl/result_uart_tx.sv
// UART 8N1 transmitter for multiply results: takes one DATA_BYTES-wide word per
// valid/ready handshake and shifts it out LSB byte first, LSB bit first, on tx.
module result_uart_tx #(
  parameter int CLKS_PER_BIT = 87,
  parameter int DATA_BYTES   = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [8*DATA_BYTES-1:0] data_in,
  input  logic                    valid_in,
  output logic                    ready_out,
  output logic                    tx,
  output logic                    busy,
  output logic                    done
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int BYTE_W = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(DATA_BYTES - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic [1:0]              state_q,   state_d;
  logic [BAUD_W-1:0]       baudCnt_q, baudCnt_d;
  logic [2:0]              bitCnt_q,  bitCnt_d;
  logic [BYTE_W-1:0]       byteCnt_q, byteCnt_d;
  logic [8*DATA_BYTES-1:0] shift_q,   shift_d;
  logic                    tx_q,      tx_d;
  logic                    busy_q,    busy_d;
  logic                    done_q,    done_d;
  logic                    baudWrap;

  assign baudWrap = (baudCnt_q == BAUD_LAST);

  // The shift register moves one place per data bit, so after eight shifts the
  // next byte of the word already sits in the low byte for the following frame.
  always_comb begin
    state_d   = state_q;
    baudCnt_d = baudCnt_q;
    bitCnt_d  = bitCnt_q;
    byteCnt_d = byteCnt_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
    busy_d    = busy_q;
    done_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        baudCnt_d = '0;
        if (valid_in && !busy_q) begin
          shift_d   = data_in;
          tx_d      = 1'b0;
          busy_d    = 1'b1;
          bitCnt_d  = '0;
          byteCnt_d = '0;
          state_d   = S_START;
        end
      end
      S_START: begin
        if (baudWrap) begin
          baudCnt_d = '0;
          bitCnt_d  = '0;
          tx_d      = shift_q[0];
          state_d   = S_DATA;
        end else begin
          baudCnt_d = baudCnt_q + 1'b1;
        end
      end
      S_DATA: begin
        if (baudWrap) begin
          baudCnt_d = '0;
          shift_d   = shift_q >> 1;
          if (bitCnt_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = S_STOP;
          end else begin
            bitCnt_d = bitCnt_q + 3'd1;
            tx_d     = shift_q[1];
          end
        end else begin
          baudCnt_d = baudCnt_q + 1'b1;
        end
      end
      S_STOP: begin
        if (baudWrap) begin
          baudCnt_d = '0;
          if (byteCnt_q == BYTE_LAST) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            byteCnt_d = byteCnt_q + 1'b1;
            tx_d      = 1'b0;
            state_d   = S_START;
          end
        end else begin
          baudCnt_d = baudCnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      baudCnt_q <= '0;
      bitCnt_q  <= '0;
      byteCnt_q <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      baudCnt_q <= baudCnt_d;
      bitCnt_q  <= bitCnt_d;
      byteCnt_q <= byteCnt_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign tx        = tx_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign ready_out = !busy_q;

endmodule

// File: tb/tb_result_uart_tx.sv
// Self-checking bench for result_uart_tx: directed steps plus a serial-line decoder
// that compares every received byte against a scoreboard of sent bytes.
module tb_result_uart_tx;

  localparam int CPB = 4;
  localparam int DB  = 2;
  localparam int FRAME = DB * 10 * CPB;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] data_in = 16'h0000;
  logic        valid_in = 1'b0;
  logic        ready_out, tx, busy, done;

  int total = 0;
  int bad = 0;
  int cycle = 0;
  int acceptCycle = 0;
  int framesSeen = 0;
  bit invOn = 1'b0;

  logic [7:0] sb[$];

  bit expSeq [20] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1,
                      1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

  result_uart_tx #(.CLKS_PER_BIT(CPB), .DATA_BYTES(DB)) dut (
    .clk       (clk),
    .rst       (rst),
    .data_in   (data_in),
    .valid_in  (valid_in),
    .ready_out (ready_out),
    .tx        (tx),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for ready, presents the word for one edge, and queues its bytes.
  task automatic applyStimulus(input logic [15:0] word, input bit holdValid);
    int waited = 0;
    while (ready_out !== 1'b1 && waited < 200) begin
      tick();
      waited++;
    end
    checkOutput("ready_before_send", {31'd0, ready_out}, 32'd1);
    data_in  = word;
    valid_in = 1'b1;
    sb.push_back(word[7:0]);
    sb.push_back(word[15:8]);
    tick();
    acceptCycle = cycle;
    if (!holdValid) valid_in = 1'b0;
  endtask

  task automatic waitDone(input string tag);
    int waited = 0;
    while (done !== 1'b1 && waited < 300) begin
      tick();
      waited++;
    end
    checkOutput({tag, "_frame_len"}, cycle - acceptCycle, FRAME);
    tick();
    checkOutput({tag, "_done_one_cycle"}, {31'd0, done}, 32'd0);
  endtask

  // Serial decoder: samples each bit in its middle on the falling edge.
  bit         decBusy = 1'b0;
  int         decCnt = 0;
  logic [7:0] decByte = 8'h00;
  logic [7:0] expByte;

  always @(negedge clk) begin
    if (rst) begin
      decBusy = 1'b0;
      decCnt  = 0;
    end else if (!decBusy) begin
      if (tx === 1'b0) begin
        decBusy = 1'b1;
        decCnt  = 0;
      end
    end else begin
      decCnt++;
      if (decCnt == 2) begin
        checkOutput("dec_start_bit", {31'd0, tx}, 32'd0);
      end else if (decCnt >= 6 && decCnt <= 34 && (decCnt % CPB) == 2) begin
        decByte[(decCnt - 6) / CPB] = tx;
      end else if (decCnt == 38) begin
        checkOutput("dec_stop_bit", {31'd0, tx}, 32'd1);
        decBusy = 1'b0;
        framesSeen++;
        if (sb.size() == 0) begin
          checkOutput("dec_unexpected_byte", 32'd1, 32'd0);
        end else begin
          expByte = sb.pop_front();
          checkOutput("dec_byte", {24'd0, decByte}, {24'd0, expByte});
        end
      end
    end
  end

  always @(negedge clk) begin
    if (invOn) begin
      checkOutput("inv_ready_not_busy", {31'd0, ready_out}, {31'd0, ~busy});
      if (done === 1'b1) checkOutput("inv_done_ready", {31'd0, ready_out}, 32'd1);
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit sawDone;
    int waited;

    rst = 1'b1;
    tick();
    rst = 1'b0;
    invOn = 1'b1;
    checkOutput("reset_tx", {31'd0, tx}, 32'd1);
    checkOutput("reset_ready", {31'd0, ready_out}, 32'd1);
    checkOutput("reset_busy", {31'd0, busy}, 32'd0);
    checkOutput("reset_done", {31'd0, done}, 32'd0);

    $display("[TB] step 1: 0xA55A bit sequence");
    applyStimulus(16'hA55A, 1'b0);
    for (int b = 0; b < 20; b++) begin
      tick();
      tick();
      checkOutput($sformatf("t1_bit%0d", b), {31'd0, tx}, {31'd0, expSeq[b]});
      checkOutput("t1_busy", {31'd0, busy}, 32'd1);
      tick();
      tick();
    end
    checkOutput("t1_done_at_80", {31'd0, done}, 32'd1);
    checkOutput("t1_len", cycle - acceptCycle, FRAME);
    tick();
    checkOutput("t1_done_pulse", {31'd0, done}, 32'd0);

    $display("[TB] step 2: reset then idle");
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      checkOutput("t2_idle_line", {28'd0, tx, ready_out, busy, done}, 32'b1100);
      tick();
    end

    $display("[TB] step 3: valid ignored while busy");
    applyStimulus(16'h1234, 1'b0);
    repeat (29) tick();
    data_in  = 16'hFFFF;
    valid_in = 1'b1;
    tick();
    valid_in = 1'b0;
    waitDone("t3");
    checkOutput("t3_sb_empty", sb.size(), 32'd0);

    $display("[TB] step 4: back-to-back words");
    applyStimulus(16'h00FF, 1'b1);
    waited = 0;
    while (done !== 1'b1 && waited < 300) begin
      tick();
      waited++;
    end
    checkOutput("t4_first_len", cycle - acceptCycle, FRAME);
    data_in = 16'h0F0F;
    sb.push_back(8'h0F);
    sb.push_back(8'h0F);
    tick();
    acceptCycle = cycle;
    valid_in = 1'b0;
    checkOutput("t4_start_no_gap_tx", {31'd0, tx}, 32'd0);
    checkOutput("t4_start_no_gap_busy", {31'd0, busy}, 32'd1);
    waitDone("t4");
    checkOutput("t4_sb_empty", sb.size(), 32'd0);

    $display("[TB] step 5: reset mid-frame");
    applyStimulus(16'hC3E1, 1'b0);
    repeat (24) tick();
    rst = 1'b1;
    sb.delete();
    tick();
    rst = 1'b0;
    checkOutput("t5_tx_after_rst", {31'd0, tx}, 32'd1);
    checkOutput("t5_ready_after_rst", {31'd0, ready_out}, 32'd1);
    checkOutput("t5_busy_after_rst", {31'd0, busy}, 32'd0);
    sawDone = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (done === 1'b1) sawDone = 1'b1;
      tick();
    end
    checkOutput("t5_no_done", {31'd0, sawDone}, 32'd0);
    applyStimulus(16'h5AC3, 1'b0);
    waitDone("t5");
    checkOutput("t5_sb_empty", sb.size(), 32'd0);

    $display("[TB] step 6: all-zero and all-one words");
    applyStimulus(16'h0000, 1'b0);
    for (int off = 0; off < FRAME; off++) begin
      checkOutput($sformatf("t6_zero_off%0d", off), {31'd0, tx}, ((off % 40) < 36) ? 32'd0 : 32'd1);
      tick();
    end
    checkOutput("t6_zero_done", {31'd0, done}, 32'd1);
    applyStimulus(16'hFFFF, 1'b0);
    for (int off = 0; off < FRAME; off++) begin
      checkOutput($sformatf("t6_ones_off%0d", off), {31'd0, tx}, ((off % 40) < 4) ? 32'd0 : 32'd1);
      tick();
    end
    checkOutput("t6_ones_done", {31'd0, done}, 32'd1);
    repeat (4) tick();

    checkOutput("final_sb_empty", sb.size(), 32'd0);
    checkOutput("final_frames", framesSeen, 32'd14);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
